spi_cmd_parser: RTL
===================

SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, register address width; command byte = {rw, addr[6:0]}.
REQ-002 Parameter MAX_ADDR, default 127, highest valid register address; must not exceed 2^ADDR_WIDTH-1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous to clk and active-high.
REQ-005 frame_active  input  1  high while the SPI chip select is asserted (already synchronised upstream).
REQ-006 byte_valid  input  1  one-cycle strobe: a received byte is on byte_in.
REQ-007 byte_in  input  8  received SPI byte, MSB first as assembled upstream.
REQ-008 tx_byte  output  8  next byte to shift out on MISO; sampled upstream at byte boundaries.
REQ-009 wr_en  output  1  one-cycle register write strobe.
REQ-010 wr_addr  output  ADDR_WIDTH  write address.
REQ-011 wr_data  output  8  write data.
REQ-012 rd_en  output  1  one-cycle register read strobe.
REQ-013 rd_addr  output  ADDR_WIDTH  read address.
REQ-014 rd_data  input  8  read data; valid exactly 1 clk after rd_en.

Function
REQ-015 States SHALL be IDLE, CMD, WR_DATA, RD_DATA, DRAIN.
REQ-016 IDLE->CMD on frame_active rising; any state->IDLE on frame_active low, with no strobe issued for a byte_valid in that same cycle.
REQ-017 In CMD, byte_valid SHALL latch rw=byte_in[7], addr=byte_in[6:0]; rw=0 -> WR_DATA, rw=1 -> RD_DATA.
REQ-018 CMD with addr > MAX_ADDR SHALL set addr_err and go to DRAIN.
REQ-019 On entering CMD, tx_byte SHALL equal status byte {frame_cnt[5:0], addr_err, ovr_err}.
REQ-020 frame_cnt SHALL increment mod 64 on each frame_active rising edge.
REQ-021 addr_err and ovr_err SHALL be sticky and clear on the CMD-byte byte_valid (status byte has then been shifted out); a new error in the same cycle wins.
REQ-022 WR_DATA: each byte_valid SHALL pulse wr_en 1 cycle later with the current address and byte_in, then advance the address per REQ-035/036.
REQ-023 RD_DATA: rd_en SHALL pulse 1 cycle after the command byte_valid and 1 cycle after each later byte_valid; tx_byte SHALL load rd_data 2 cycles after that byte_valid.
REQ-024 Address advance past MAX_ADDR SHALL set addr_err and go to DRAIN, with no strobe for the out-of-range address.
REQ-025 A byte_valid arriving while a read fetch is still pending (within 2 cycles of the prior byte_valid) SHALL set ovr_err and be ignored.
REQ-026 DRAIN SHALL ignore bytes, drive tx_byte=8'h00, and issue no strobes until frame end.
REQ-027 In IDLE, tx_byte SHALL hold the current status byte.
REQ-028 wr_en and rd_en SHALL never be high in the same cycle, and never outside a frame.

Reset
REQ-029 rst SHALL force IDLE and all outputs to 0.
REQ-030 rst SHALL clear frame_cnt, addr_err, ovr_err and the address register.
REQ-031 rst SHALL override every other input in the same cycle.
REQ-032 If frame_active is high when rst releases, the block SHALL wait in IDLE for frame_active low, then high, before starting a frame (no mid-frame pickup).

Configuration
REQ-033 Macro SPI_CMD_PARSER_AUTOINC_EN SHALL select address advance behaviour.
REQ-034 The macro SHALL have no effect on the command byte, status byte or error behaviour.
REQ-035 Defined: the address SHALL increment by 1 after each data byte (burst access).
REQ-036 Undefined: the address SHALL stay fixed for the whole frame (repeated access to one register), and REQ-024 never triggers.

Verification
REQ-037 Write burst: frame, bytes 0x05,0xAA,0xBB -> wr_en pulses (0x05,0xAA) then (0x06,0xBB) with AUTOINC, or (0x05,0xBB) without it; tx_byte in CMD = {1,0,0}.
REQ-038 Read: bytes 0x90,0x00 with rd_data=0x3C at addr 0x10 -> rd_en at addr 0x10 1 cycle after byte 1; tx_byte=0x3C 2 cycles after byte 1.
REQ-039 Bad address with MAX_ADDR=15: byte 0x20 -> no strobes, tx_byte=0x00; next frame status bit1=1, cleared after its CMD byte.
REQ-040 Overrun: in RD_DATA, byte_valid 1 cycle after the previous one -> second byte ignored, ovr_err=1 in next frame's status.
REQ-041 Mid-frame reset: rst during WR_DATA with frame_active held high -> no wr_en until frame_active goes low then high; frame_cnt=1 after that new frame starts.
REQ-042 frame_active low in the same cycle as byte_valid -> no wr_en/rd_en issued; state returns to IDLE.

Source files
------------

// File: rtl/spi_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_parser_if
//
// Bundles the byte-level SPI side and the register-file side of the command
// parser into a single interface.
//
//   frame_active : chip select asserted (already synchronised upstream)
//   byte_valid   : one-cycle strobe, byte_in holds a received byte
//   byte_in      : received SPI byte
//   tx_byte      : next byte to shift out on MISO
//   wr_en        : one-cycle register write strobe
//   wr_addr      : register write address
//   wr_data      : register write data
//   rd_en        : one-cycle register read strobe
//   rd_addr      : register read address
//   rd_data      : register read data, valid one clock after rd_en
//
// Modports:
//   master : the SPI front end / register file side that drives the parser
//   slave  : the parser itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_cmd_parser_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  frame_active;
  logic                  byte_valid;
  logic [7:0]            byte_in;
  logic [7:0]            tx_byte;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;

  modport master (
    output frame_active, byte_valid, byte_in, rd_data,
    input  tx_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    input  frame_active, byte_valid, byte_in, rd_data,
    output tx_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// -----------------------------------------------------------------------------
// spi_cmd_parser
//
// Turns a stream of received SPI bytes into register read/write strobes.
// The first byte of each frame is a command {rw, addr[6:0]}; the following
// bytes are write data (rw=0) or dummy bytes that clock out read data (rw=1).
// While the command byte is being shifted in, MISO carries a status byte
// {frame_cnt[5:0], addr_err, ovr_err}.
//
// Parameters:
//   ADDR_WIDTH : register address width (command carries up to 7 bits)
//   MAX_ADDR   : highest valid register address (<= 2**ADDR_WIDTH-1)
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : spi_cmd_parser_if.slave (frame/byte inputs, tx_byte, wr_*/rd_*)
//
// Build option:
//   SPI_CMD_PARSER_AUTOINC_EN defined   : address increments after each data
//                                         byte (burst access); running past
//                                         MAX_ADDR raises addr_err and drains.
//   SPI_CMD_PARSER_AUTOINC_EN undefined : address stays fixed for the frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_cmd_parser #(
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_ADDR   = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cmd_parser_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_DATA = 3'd2,
    RD_DATA = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0]            MAX_CMD = 8'(MAX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MAX_A   = ADDR_WIDTH'(MAX_ADDR);

  state_t                state_q;
  state_t                state_d;

  logic                  fa_q;
  logic                  fa_rise;
  logic                  byte_in_frame;

  logic [5:0]            frame_cnt_q;
  logic [5:0]            frame_cnt_d;
  logic                  addr_err_q;
  logic                  addr_err_d;
  logic                  ovr_err_q;
  logic                  ovr_err_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_adv;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_bad;
  logic                  adv_ovf;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [7:0]            wr_data_d;
  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [7:0]            tx_d;

  logic                  wr_en_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [7:0]            wr_data_p1;
  logic                  rd_en_p1;
  logic [ADDR_WIDTH-1:0] rd_addr_p1;
  logic                  vld_p2;
  logic [7:0]            tx_q;

  logic                  rd_busy;
  logic                  rd_return;

  function automatic logic [7:0] status_byte(input logic [5:0] cnt,
                                             input logic       a_err,
                                             input logic       o_err);
    return {cnt, a_err, o_err};
  endfunction

  function automatic logic cmd_addr_bad(input logic [7:0] cmd);
    return {1'b0, cmd[6:0]} > MAX_CMD;
  endfunction

  // frame_active is sampled every cycle, reset or not, so a frame that is
  // already open when rst releases never produces a rising edge.
  always_ff @(posedge clk) begin
    fa_q <= bus.frame_active;
  end

  assign fa_rise       = bus.frame_active & ~fa_q;
  assign byte_in_frame = bus.byte_valid & bus.frame_active;
  assign cmd_addr      = bus.byte_in[ADDR_WIDTH-1:0];
  assign cmd_bad       = cmd_addr_bad(bus.byte_in);

`ifdef SPI_CMD_PARSER_AUTOINC_EN
  assign adv_ovf  = (addr_q >= MAX_A);
  assign addr_adv = addr_q + ADDR_WIDTH'(1);
`else
  assign adv_ovf  = 1'b0;
  assign addr_adv = addr_q;
`endif

  // A read fetch occupies the cycle of rd_en and the return cycle after it;
  // a byte arriving in either of those cycles would outrun the fetch.
  assign rd_busy   = rd_en_p1 | vld_p2;
  assign rd_return = (state_q == RD_DATA) & vld_p2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.frame_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fa_rise) state_d = CMD;
        end
        CMD: begin
          if (bus.byte_valid) begin
            if (cmd_bad)             state_d = DRAIN;
            else if (bus.byte_in[7]) state_d = RD_DATA;
            else                     state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.byte_valid && adv_ovf) state_d = DRAIN;
        end
        RD_DATA: begin
          if (bus.byte_valid && !rd_busy && adv_ovf) state_d = DRAIN;
        end
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    addr_err_d  = addr_err_q;
    ovr_err_d   = ovr_err_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_p1;
    wr_data_d   = wr_data_p1;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_p1;

    if ((state_q == IDLE) && fa_rise) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
    end

    if (byte_in_frame) begin
      case (state_q)
        CMD: begin
          // The status byte has just been shifted out, so the sticky flags
          // clear here; a bad address in this very byte sets addr_err again.
          addr_err_d = cmd_bad;
          ovr_err_d  = 1'b0;
          addr_d     = cmd_addr;
          if (!cmd_bad && bus.byte_in[7]) begin
            rd_en_d   = 1'b1;
            rd_addr_d = cmd_addr;
          end
        end
        WR_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.byte_in;
          if (adv_ovf) addr_err_d = 1'b1;
          else         addr_d     = addr_adv;
        end
        RD_DATA: begin
          if (rd_busy) begin
            ovr_err_d = 1'b1;
          end else if (adv_ovf) begin
            addr_err_d = 1'b1;
          end else begin
            addr_d    = addr_adv;
            rd_en_d   = 1'b1;
            rd_addr_d = addr_adv;
          end
        end
        default: ;
      endcase
    end

    if (state_d == DRAIN) begin
      tx_d = 8'h00;
    end else if ((state_d == IDLE) || (state_d == CMD)) begin
      tx_d = status_byte(frame_cnt_d, addr_err_d, ovr_err_d);
    end else if (rd_return) begin
      tx_d = bus.rd_data;
    end else begin
      tx_d = tx_q;
    end
  end

  // Stage p1: strobes and registered control/status
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      addr_err_q  <= 1'b0;
      ovr_err_q   <= 1'b0;
      addr_q      <= '0;
      wr_en_p1    <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
      rd_en_p1    <= 1'b0;
      rd_addr_p1  <= '0;
      tx_q        <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      addr_err_q  <= addr_err_d;
      ovr_err_q   <= ovr_err_d;
      addr_q      <= addr_d;
      wr_en_p1    <= wr_en_d;
      wr_addr_p1  <= wr_addr_d;
      wr_data_p1  <= wr_data_d;
      rd_en_p1    <= rd_en_d;
      rd_addr_p1  <= rd_addr_d;
      tx_q        <= tx_d;
    end
  end

  // Stage p2: read data returns from the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= rd_en_p1;
    end
  end

  // Returned read data goes straight to MISO in its return cycle and is
  // held in tx_q afterwards.
  assign bus.tx_byte = rd_return ? bus.rd_data : tx_q;
  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.wr_data = wr_data_p1;
  assign bus.rd_en   = rd_en_p1;
  assign bus.rd_addr = rd_addr_p1;

endmodule
